im_result_streamer: RTL and testbench
=====================================

// Module: im_result_streamer
// PURPOSE
//  Drain side of the IM/tao calculation: captures the 18-cell IM and tao vectors in one cycle when the
//  calculator pulses its valid. Replays them as a serial valid/ready stream of one cell per beat,
//  in cell order idx = k*9+i*3+j, toward the score reducer / result FIFO.
//  Its busy output gates the issuer so that a new calculation starts only after the stream has drained.
// PARAMETERS
//  FLOAT_WIDTH  32  width of one IM or tao word (IEEE-754 single)
//  NUM_CELLS    18  cells per result vector (3x3x2 genotype table); idx width fixed at 5 bits
// PORTS
//  clk           in   1                 clock
//  rst           in   1                 synchronous, active-high reset
//  im_in         in   NUM_CELLS*32      IM vector; cell c at [c*FLOAT_WIDTH +: FLOAT_WIDTH]
//  tao_in        in   NUM_CELLS*32      tao vector, same packing
//  data_valid_in in   1                 1-cycle pulse: vectors valid this cycle
//  out_valid     out  1                 stream beat valid
//  out_ready     in   1                 downstream accepts beat
//  out_im        out  FLOAT_WIDTH       IM of current cell
//  out_tao       out  FLOAT_WIDTH       tao of current cell
//  out_idx       out  5                 cell index 0..NUM_CELLS-1
//  out_last      out  1                 current beat is final beat of this vector
//  done          out  1                 1-cycle pulse, cycle after final handshake
//  busy          out  1                 vector held, stream not finished
//  overflow      out  1                 sticky: data_valid_in arrived while busy and was dropped
//  clr_overflow  in   1                 clears overflow
// BEHAVIOUR
//  - Reset: state IDLE, out_valid=0, out_last=0, done=0, busy=0, overflow=0, out_idx=0.
//    Capture registers are not reset (don't-care).
//  - States: IDLE, STREAM.
//    IDLE --data_valid_in--> STREAM.
//    STREAM --handshake with out_last=1--> IDLE, or back to STREAM if a new vector is captured that same cycle.
//  - Capture: on data_valid_in while IDLE, or in the same cycle as the final handshake, latch both full vectors.
//    Set out_idx to the first cell. out_valid=1 and busy=1 from the next cycle. Latency: pulse at T, first beat at T+1.
//  - Handshake: a beat transfers when out_valid && out_ready.
//    On transfer, advance to the next cell; otherwise hold out_im/out_tao/out_idx/out_last stable.
//    out_valid never drops without a transfer except on rst.
//  - out_last=1 exactly on the highest emitted cell. Full-rate back-to-back: 18 beats in 18 cycles.
//  - done pulses the cycle after the final transfer. busy falls the same cycle unless a new vector was captured.
//  - data_valid_in while busy and not on the final-handshake cycle: vector dropped, overflow<=1, stream unaffected.
//    overflow stays set until rst or clr_overflow.
//    clr_overflow and a new drop in the same cycle: overflow stays 1 (set wins).
//  - rst mid-stream: everything returns to reset values next cycle; no done pulse, remaining beats lost.
//  - Data words pass through unchanged, no float arithmetic.
// CONFIGURATION
//  IM_STREAM_SKIP_ZERO_EN: defined -> at capture build an 18-bit mask of cells whose tao is nonzero.
//    +0.0 (0x00000000) and -0.0 (0x80000000) both count as zero.
//    Only masked cells are emitted; out_idx still reports the original cell index.
//    out_last marks the highest set mask bit.
//    All-zero mask: no beats; done pulses at T+1, busy stays 0, state returns straight to IDLE.
//  Undefined -> all NUM_CELLS cells always emitted; no mask logic synthesized.
// TESTING
//  1. rst, capture a vector with im[c]=c, tao[c]=0x3F800000, out_ready=1 -> beats at T+1..T+18 with idx 0..17.
//     out_last only on idx 17, done at T+19, busy high T+1..T+18.
//  2. Same vector with out_ready toggling 1010... -> 18 beats, payload stable while stalled, done after 36 cycles.
//  3. Second data_valid_in at beat idx 5 -> overflow=1, stream completes unchanged.
//     clr_overflow -> overflow=0 next cycle.
//  4. Second data_valid_in on the final-handshake cycle -> no overflow, no gap.
//     Next vector's idx 0 appears the following cycle, done pulses once for the first vector.
//  5. rst asserted at beat idx 9 -> out_valid=0, busy=0 next cycle, no done pulse.
//     A new vector afterwards streams from idx 0.
//  6. (SKIP_ZERO_EN) tao nonzero only at cells 2, 11, 17 (17 as -0.0) -> beats idx 2, 11 only, out_last on 11.
//     All-zero tao -> zero beats, done at T+1.

Source files
------------

// File: rtl/im_result_streamer.sv
// im_result_streamer
// Captures the 18-cell IM and tao result vectors from the calculator in a
// single cycle and replays them as a serial stream of one cell per beat, in
// cell order. busy is high while a captured vector is still being streamed,
// which holds off the issuer until the stream has drained.
//
// Handshake: a beat transfers on any rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and no transfer happens,
// out_im/out_tao/out_idx/out_last hold steady. out_valid only drops after a
// transfer or on rst.
//
// Optional build macro IM_STREAM_SKIP_ZERO_EN: only cells whose tao is
// nonzero (+0.0 and -0.0 both count as zero) are emitted. out_idx still
// reports the original cell index. A vector with no nonzero tao emits no
// beats and only pulses done.
module im_result_streamer #(
    parameter int FLOAT_WIDTH = 32,
    parameter int NUM_CELLS   = 18
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CELLS*FLOAT_WIDTH-1:0] im_in,
    input  logic [NUM_CELLS*FLOAT_WIDTH-1:0] tao_in,
    input  logic                           data_valid_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [FLOAT_WIDTH-1:0]         out_im,
    output logic [FLOAT_WIDTH-1:0]         out_tao,
    output logic [4:0]                     out_idx,
    output logic                           out_last,
    output logic                           done,
    output logic                           busy,
    output logic                           overflow,
    input  logic                           clr_overflow
);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t state, state_nxt;

    logic [FLOAT_WIDTH-1:0] im_mem  [NUM_CELLS];
    logic [FLOAT_WIDTH-1:0] tao_mem [NUM_CELLS];

    logic [4:0] idx_q;
    logic       done_q;
    logic       overflow_q;

    logic       hs;
    logic       final_hs;
    logic       capture;
    logic       drop;

    // first_idx: first cell of the vector being captured now
    // next_idx : cell following the current one in the stream
    // last_idx : final cell of the vector currently held
    // any_cell : the vector being captured now has at least one beat
    logic [4:0] first_idx;
    logic [4:0] next_idx;
    logic [4:0] last_idx;
    logic       any_cell;

`ifdef IM_STREAM_SKIP_ZERO_EN
    logic [NUM_CELLS-1:0] mask_in;
    logic [NUM_CELLS-1:0] mask_q;

    // Lowest set bit of m at or above position from (0 when none).
    function automatic logic [4:0] find_up(input logic [NUM_CELLS-1:0] m, input int from);
        logic [4:0] r;
        r = '0;
        for (int c = NUM_CELLS - 1; c >= 0; c--) begin
            if (m[c] && c >= from) r = 5'(c);
        end
        return r;
    endfunction

    // Highest set bit of m (0 when none).
    function automatic logic [4:0] find_top(input logic [NUM_CELLS-1:0] m);
        logic [4:0] r;
        r = '0;
        for (int c = 0; c < NUM_CELLS; c++) begin
            if (m[c]) r = 5'(c);
        end
        return r;
    endfunction

    // A cell is kept when its tao magnitude bits are nonzero; the sign bit is
    // ignored so that -0.0 is treated like +0.0.
    always_comb begin
        mask_in = '0;
        for (int c = 0; c < NUM_CELLS; c++) begin
            mask_in[c] = (tao_in[c*FLOAT_WIDTH +: FLOAT_WIDTH-1] != '0);
        end
    end

    // Keep-mask of the held vector, latched together with the data.
    always_ff @(posedge clk) begin
        if (capture) mask_q <= mask_in;
    end

    assign first_idx = find_up(mask_in, 0);
    assign any_cell  = |mask_in;
    assign next_idx  = find_up(mask_q, int'(idx_q) + 1);
    assign last_idx  = find_top(mask_q);
`else
    localparam logic [4:0] LAST_CELL = 5'(NUM_CELLS - 1);

    assign first_idx = '0;
    assign any_cell  = 1'b1;
    assign next_idx  = idx_q + 5'd1;
    assign last_idx  = LAST_CELL;
`endif

    assign hs       = out_valid && out_ready;
    assign final_hs = hs && out_last;
    // A new vector is accepted when idle, or on the final handshake so that
    // back-to-back vectors stream without a gap.
    assign capture  = data_valid_in && ((state == IDLE) || final_hs);
    assign drop     = data_valid_in && (state == STREAM) && !final_hs;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture && any_cell) state_nxt = STREAM;
            STREAM:  if (final_hs)            state_nxt = (capture && any_cell) ? STREAM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state and the current cell pointer.
    always_comb begin
        out_valid = (state == STREAM);
        busy      = (state == STREAM);
        out_last  = (state == STREAM) && (idx_q == last_idx);
        out_idx   = idx_q;
        out_im    = im_mem[idx_q];
        out_tao   = tao_mem[idx_q];
        done      = done_q;
        overflow  = overflow_q;
    end

    // Latch both full vectors on capture; contents are don't-care out of reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int c = 0; c < NUM_CELLS; c++) begin
                im_mem[c]  <= im_in[c*FLOAT_WIDTH +: FLOAT_WIDTH];
                tao_mem[c] <= tao_in[c*FLOAT_WIDTH +: FLOAT_WIDTH];
            end
        end
    end

    // Cell pointer: load first cell on capture, advance on each transfer.
    always_ff @(posedge clk) begin
        if (rst)           idx_q <= '0;
        else if (capture)  idx_q <= first_idx;
        else if (final_hs) idx_q <= '0;
        else if (hs)       idx_q <= next_idx;
    end

    // done pulses after the final transfer, or right away for an empty vector.
    always_ff @(posedge clk) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= final_hs || (capture && !any_cell);
    end

    // Sticky overflow on a dropped vector; a new drop beats a clear.
    always_ff @(posedge clk) begin
        if (rst)               overflow_q <= 1'b0;
        else if (drop)         overflow_q <= 1'b1;
        else if (clr_overflow) overflow_q <= 1'b0;
    end

endmodule

// File: tb/tb_im_result_streamer.sv
// Directed bench for im_result_streamer: full-rate stream, stalled stream,
// overflow handling, back-to-back vectors, mid-stream reset and, when built
// with IM_STREAM_SKIP_ZERO_EN, zero-tao cell skipping.
module tb_im_result_streamer;

    localparam int FW = 32;
    localparam int NC = 18;
    localparam logic [31:0] ONE_F = 32'h3F800000;

    logic                 clk;
    logic                 rst;
    logic [NC*FW-1:0]     im_in;
    logic [NC*FW-1:0]     tao_in;
    logic                 data_valid_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [FW-1:0]        out_im;
    logic [FW-1:0]        out_tao;
    logic [4:0]           out_idx;
    logic                 out_last;
    logic                 done;
    logic                 busy;
    logic                 overflow;
    logic                 clr_overflow;

    int n_checks;
    int n_fail;

    im_result_streamer #(.FLOAT_WIDTH(FW), .NUM_CELLS(NC)) dut (
        .clk(clk),
        .rst(rst),
        .im_in(im_in),
        .tao_in(tao_in),
        .data_valid_in(data_valid_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_im(out_im),
        .out_tao(out_tao),
        .out_idx(out_idx),
        .out_last(out_last),
        .done(done),
        .busy(busy),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed view of the DUT outputs:
    // {overflow, out_valid, busy, done, out_last, out_idx, out_im, out_tao}
    function automatic logic [73:0] obs();
        return {overflow, out_valid, busy, done, out_last, out_idx, out_im, out_tao};
    endfunction

    // Control-only view: {overflow, out_valid, busy, done}
    function automatic logic [3:0] ctl();
        return {overflow, out_valid, busy, done};
    endfunction

    task automatic set_vec(input int im_base, input logic [31:0] tao_val);
        for (int c = 0; c < NC; c++) begin
            im_in[c*FW +: FW]  = 32'(im_base + c);
            tao_in[c*FW +: FW] = tao_val;
        end
    endtask

    task automatic pulse_vec();
        data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_valid_in = 1'b0;
        out_ready = 1'b0;
        clr_overflow = 1'b0;
        set_vec(0, ONE_F);
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({ctl(), out_last, out_idx} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset: got ctl=%b last=%b idx=%0d, expected all zero", ctl(), out_last, out_idx);
        end
    endtask

    task automatic test_full_rate();
        logic [73:0] exp;
        set_vec(0, ONE_F);
        out_ready = 1'b1;
        pulse_vec();
        for (int k = 0; k < NC; k++) begin
            exp = {1'b0, 1'b1, 1'b1, 1'b0, (k == 17), 5'(k), 32'(k), ONE_F};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL full_rate beat %0d: got %h expected %h", k, obs(), exp);
            end
            tick();
        end
        n_checks++;
        if (ctl() !== 4'b0001) begin
            n_fail++;
            $display("FAIL full_rate done: got ctl=%b expected 0001", ctl());
        end
        tick();
        n_checks++;
        if (ctl() !== 4'b0000) begin
            n_fail++;
            $display("FAIL full_rate after_done: got ctl=%b expected 0000", ctl());
        end
    endtask

    task automatic test_stall();
        logic [73:0] exp;
        int k;
        int cyc;
        set_vec(100, ONE_F);
        pulse_vec();
        k = 0;
        cyc = 0;
        while (k < NC && cyc < 100) begin
            out_ready = (cyc % 2 == 0);
            exp = {1'b0, 1'b1, 1'b1, 1'b0, (k == 17), 5'(k), 32'(k + 100), ONE_F};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL stall cycle %0d: got %h expected %h", cyc, obs(), exp);
            end
            if (out_ready) k++;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        n_checks++;
        if (cyc !== 35 || ctl() !== 4'b0001) begin
            n_fail++;
            $display("FAIL stall done: got cycles=%0d ctl=%b expected cycles=35 ctl=0001", cyc, ctl());
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [73:0] exp;
        set_vec(0, ONE_F);
        out_ready = 1'b1;
        pulse_vec();
        for (int k = 0; k < NC; k++) begin
            exp = {(k > 5), 1'b1, 1'b1, 1'b0, (k == 17), 5'(k), 32'(k), ONE_F};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL overflow beat %0d: got %h expected %h", k, obs(), exp);
            end
            data_valid_in = (k == 5) || (k == 8);
            clr_overflow  = (k == 8);
            if (k == 5) set_vec(999, 32'h12345678);
            tick();
            data_valid_in = 1'b0;
            clr_overflow  = 1'b0;
        end
        n_checks++;
        if (ctl() !== 4'b1001) begin
            n_fail++;
            $display("FAIL overflow done: got ctl=%b expected 1001", ctl());
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        n_checks++;
        if (ctl() !== 4'b0000) begin
            n_fail++;
            $display("FAIL overflow clear: got ctl=%b expected 0000", ctl());
        end
    endtask

    task automatic test_back_to_back();
        logic [73:0] exp;
        set_vec(0, ONE_F);
        out_ready = 1'b1;
        pulse_vec();
        for (int k = 0; k < NC; k++) begin
            exp = {1'b0, 1'b1, 1'b1, 1'b0, (k == 17), 5'(k), 32'(k), ONE_F};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL b2b first beat %0d: got %h expected %h", k, obs(), exp);
            end
            if (k == 17) begin
                set_vec(200, ONE_F);
                data_valid_in = 1'b1;
            end
            tick();
            data_valid_in = 1'b0;
        end
        for (int k = 0; k < NC; k++) begin
            exp = {1'b0, 1'b1, 1'b1, (k == 0), (k == 17), 5'(k), 32'(k + 200), ONE_F};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL b2b second beat %0d: got %h expected %h", k, obs(), exp);
            end
            tick();
        end
        n_checks++;
        if (ctl() !== 4'b0001) begin
            n_fail++;
            $display("FAIL b2b done: got ctl=%b expected 0001", ctl());
        end
        tick();
    endtask

    task automatic test_rst_mid();
        logic [73:0] exp;
        set_vec(300, ONE_F);
        out_ready = 1'b1;
        pulse_vec();
        for (int k = 0; k < 10; k++) begin
            exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'(k), 32'(k + 300), ONE_F};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL rst_mid beat %0d: got %h expected %h", k, obs(), exp);
            end
            if (k == 9) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        n_checks++;
        if ({ctl(), out_last, out_idx} !== 10'b0) begin
            n_fail++;
            $display("FAIL rst_mid reset: got ctl=%b last=%b idx=%0d expected zero", ctl(), out_last, out_idx);
        end
        tick();
        n_checks++;
        if (ctl() !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid no_done: got ctl=%b expected 0000", ctl());
        end
        set_vec(400, ONE_F);
        pulse_vec();
        for (int k = 0; k < NC; k++) begin
            exp = {1'b0, 1'b1, 1'b1, 1'b0, (k == 17), 5'(k), 32'(k + 400), ONE_F};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL rst_mid restream beat %0d: got %h expected %h", k, obs(), exp);
            end
            tick();
        end
        n_checks++;
        if (ctl() !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid restream done: got ctl=%b expected 0001", ctl());
        end
        tick();
    endtask

`ifdef IM_STREAM_SKIP_ZERO_EN
    task automatic test_skip_zero();
        logic [73:0] exp;
        set_vec(500, 32'h0);
        tao_in[2*FW +: FW]  = ONE_F;
        tao_in[11*FW +: FW] = 32'h40000000;
        tao_in[17*FW +: FW] = 32'h80000000;
        out_ready = 1'b1;
        pulse_vec();
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'd502, ONE_F};
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL skip beat idx2: got %h expected %h", obs(), exp);
        end
        tick();
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 32'd511, 32'h40000000};
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL skip beat idx11: got %h expected %h", obs(), exp);
        end
        tick();
        n_checks++;
        if (ctl() !== 4'b0001) begin
            n_fail++;
            $display("FAIL skip done: got ctl=%b expected 0001", ctl());
        end
        tick();
        set_vec(0, 32'h0);
        tao_in[4*FW +: FW] = 32'h80000000;
        pulse_vec();
        n_checks++;
        if (ctl() !== 4'b0001) begin
            n_fail++;
            $display("FAIL skip all_zero done: got ctl=%b expected 0001", ctl());
        end
        tick();
        n_checks++;
        if (ctl() !== 4'b0000) begin
            n_fail++;
            $display("FAIL skip all_zero idle: got ctl=%b expected 0000", ctl());
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_full_rate();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_rst_mid();
`ifdef IM_STREAM_SKIP_ZERO_EN
        test_skip_zero();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
